// File: rtl/keypad_pkg.sv
// Shared types and width helpers for the keypad scanner.
package keypad_pkg;

    typedef enum logic [0:0] {
        KP_IDLE = 1'b0,
        KP_HELD = 1'b1
    } kp_state_t;

    // Key code width for a COLS x ROWS matrix; never narrower than one bit.
    function automatic int unsigned kp_code_w(input int unsigned cols, input int unsigned rows);
        return (cols * rows > 1) ? $clog2(cols * rows) : 1;
    endfunction

    // A sweep candidate carries one extra MSB; the all-ones pattern means no key seen.
    localparam logic KP_NONE_BIT = 1'b1;

endpackage

// File: rtl/keypad_debounce.sv
// Sweep-level debounce FSM: accepts press, change and release after DEBOUNCE matching sweeps.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned CODE_W   = 4,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sweep_end,
    input  logic              cand_valid,
    input  logic [CODE_W-1:0] cand_code,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held,
    output logic              key_release
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

    kp_state_t         state, state_n;
    logic              prev_valid, prev_valid_n;
    logic [CODE_W-1:0] prev_code, prev_code_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [CODE_W-1:0] code_n;
    logic              valid_n, held_n, release_n;
    logic              same_c;
    logic [CNT_W-1:0]  run_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= KP_IDLE;
            prev_valid  <= 1'b0;
            prev_code   <= '0;
            cnt         <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_held    <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_n;
            prev_valid  <= prev_valid_n;
            prev_code   <= prev_code_n;
            cnt         <= cnt_n;
            key_code    <= code_n;
            key_valid   <= valid_n;
            key_held    <= held_n;
            key_release <= release_n;
        end
    end

    // Run length of the current candidate, counting this sweep.
    assign same_c = (cand_valid == prev_valid) && (!cand_valid || (cand_code == prev_code));
    assign run_c  = same_c ? (cnt + CNT_W'(1)) : CNT_W'(1);

    always_comb begin
        state_n      = state;
        prev_valid_n = prev_valid;
        prev_code_n  = prev_code;
        cnt_n        = cnt;
        code_n       = key_code;
        held_n       = key_held;
        valid_n      = 1'b0;
        release_n    = 1'b0;
        if (sweep_end) begin
            prev_valid_n = cand_valid;
            prev_code_n  = cand_code;
            case (state)
                KP_IDLE: begin
                    if (!cand_valid) begin
                        cnt_n = '0;
                    end else if (run_c >= CNT_W'(DEBOUNCE)) begin
                        cnt_n   = '0;
                        code_n  = cand_code;
                        valid_n = 1'b1;
                        held_n  = 1'b1;
                        state_n = KP_HELD;
                    end else begin
                        cnt_n = run_c;
                    end
                end
                KP_HELD: begin
                    if (cand_valid && (cand_code == key_code)) begin
                        cnt_n = '0;
                    end else if (run_c >= CNT_W'(DEBOUNCE)) begin
                        cnt_n = '0;
                        if (cand_valid) begin
                            code_n  = cand_code;
                            valid_n = 1'b1;
                        end else begin
                            release_n = 1'b1;
                            held_n    = 1'b0;
                            state_n   = KP_IDLE;
                        end
                    end else begin
                        cnt_n = run_c;
                    end
                end
                default: state_n = KP_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// Matrix keypad scanner: column rotation, row synchronizer and per-sweep lowest-code candidate.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned COLS     = 4,
    parameter int unsigned ROWS     = 4,
    parameter int unsigned SETTLE   = 4,
    parameter int unsigned DEBOUNCE = 3,
    localparam int unsigned CODE_W  = kp_code_w(COLS, ROWS)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [COLS-1:0]   col_o,
    input  logic [ROWS-1:0]   row_i,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held,
    output logic              key_release
);

    localparam int unsigned DW_W = $clog2(SETTLE);
    localparam int unsigned CI_W = $clog2(COLS);
    localparam logic [CODE_W:0] KP_NONE = {KP_NONE_BIT, {CODE_W{1'b1}}};

    logic [ROWS-1:0]   row_s1, row_s2;
    logic [DW_W-1:0]   dwell;
    logic [CI_W-1:0]   col_idx;
    logic [CODE_W:0]   acc, cand_q, cand_next;
    logic              sweep_end;
    logic              sample_c, last_col_c, col_hit;
    logic [CODE_W-1:0] row_sel, col_code;

    assign sample_c   = (dwell == DW_W'(SETTLE - 1));
    assign last_col_c = (col_idx == CI_W'(COLS - 1));

    // Lowest active row in the currently sampled column.
    always_comb begin
        col_hit = 1'b0;
        row_sel = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (row_s2[r]) begin
                col_hit = 1'b1;
                row_sel = CODE_W'(r);
            end
        end
    end

    assign col_code = CODE_W'(col_idx) * CODE_W'(ROWS) + row_sel;

    // Columns are visited in ascending code order, so the first hit of a sweep is the lowest.
    always_comb begin
        cand_next = acc;
        if ((acc == KP_NONE) && col_hit) begin
            cand_next = {1'b0, col_code};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1    <= '0;
            row_s2    <= '0;
            dwell     <= '0;
            col_idx   <= '0;
            col_o     <= {1'b1, {(COLS - 1){1'b0}}};
            acc       <= KP_NONE;
            cand_q    <= KP_NONE;
            sweep_end <= 1'b0;
        end else begin
            row_s1    <= row_i;
            row_s2    <= row_s1;
            sweep_end <= 1'b0;
            if (sample_c) begin
                dwell <= '0;
                col_o <= {col_o[0], col_o[COLS-1:1]};
                if (last_col_c) begin
                    col_idx   <= '0;
                    acc       <= KP_NONE;
                    cand_q    <= cand_next;
                    sweep_end <= 1'b1;
                end else begin
                    col_idx <= col_idx + CI_W'(1);
                    acc     <= cand_next;
                end
            end else begin
                dwell <= dwell + DW_W'(1);
            end
        end
    end

    keypad_debounce #(
        .CODE_W   (CODE_W),
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .sweep_end   (sweep_end),
        .cand_valid  (cand_q[CODE_W] != KP_NONE_BIT),
        .cand_code   (cand_q[CODE_W-1:0]),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_held    (key_held),
        .key_release (key_release)
    );

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: directed sweep table, randomized sweeps against a run-length model, async reset.
module tb_keypad_scan;

    localparam int unsigned COLS     = 4;
    localparam int unsigned ROWS     = 4;
    localparam int unsigned SETTLE   = 4;
    localparam int unsigned DEBOUNCE = 3;
    localparam int unsigned SWEEP    = COLS * SETTLE;

    localparam logic [15:0] K_NONE = 16'h0000;
    localparam logic [15:0] K3     = 16'h0008;
    localparam logic [15:0] K6     = 16'h0040;
    localparam logic [15:0] K9     = 16'h0200;

    typedef struct {
        logic [15:0] keys;
        logic        valid;
        logic        rel;
        logic [3:0]  code;
        logic        held;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  col_o;
    logic [3:0]  row_i;
    logic [3:0]  key_code;
    logic        key_valid, key_held, key_release;
    logic [15:0] pressed;

    int   checks = 0;
    int   errors = 0;
    vec_t pend;
    vec_t tbl[$];

    int          run_val, run_len;
    logic        m_held;
    logic [3:0]  m_code;

    keypad_scan #(
        .COLS     (COLS),
        .ROWS     (ROWS),
        .SETTLE   (SETTLE),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .col_o       (col_o),
        .row_i       (row_i),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_held    (key_held),
        .key_release (key_release)
    );

    always #5 clk = ~clk;

    // Physical keypad: a closed key connects its column line to its row line.
    always_comb begin
        row_i = '0;
        for (int c = 0; c < 4; c++) begin
            if (col_o[3 - c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (pressed[c * 4 + r]) row_i[r] = 1'b1;
                end
            end
        end
    end

    function automatic vec_t mk(input logic [15:0] k, input logic v, input logic r,
                                input logic [3:0] c, input logic h);
        vec_t e;
        e.keys = k; e.valid = v; e.rel = r; e.code = c; e.held = h;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [15:0] k);
        for (int i = 0; i < 16; i++) begin
            if (k[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        run_val = -2;
        run_len = 0;
        m_held  = 1'b0;
        m_code  = 4'd0;
    endtask

    // A run of DEBOUNCE identical sweep results that differs from the accepted state is an event.
    task automatic model_sweep(input logic [15:0] k, output vec_t e);
        int c, cur;
        c = lowest(k);
        if (c == run_val) run_len++;
        else begin
            run_val = c;
            run_len = 1;
        end
        cur = m_held ? int'(m_code) : -1;
        e = mk(k, 1'b0, 1'b0, 4'd0, 1'b0);
        if (run_len == int'(DEBOUNCE) && c != cur) begin
            if (c < 0) begin
                e.rel  = 1'b1;
                m_held = 1'b0;
            end else begin
                e.valid = 1'b1;
                m_code  = 4'(c);
                m_held  = 1'b1;
            end
        end
        e.code = m_code;
        e.held = m_held;
    endtask

    // One full sweep with v.keys held; checks the previous sweep's result and the column rotation.
    task automatic do_sweep(input vec_t v);
        logic       ok_col, ok_steady;
        logic [3:0] exp_col;
        pressed   = v.keys;
        ok_col    = 1'b1;
        ok_steady = 1'b1;
        for (int k = 1; k <= int'(SWEEP); k++) begin
            @(negedge clk);
            exp_col = 4'(4'b1000 >> ((k / int'(SETTLE)) % int'(COLS)));
            if (col_o !== exp_col) ok_col = 1'b0;
            if (k == 1) begin
                chk("key_valid", 32'(key_valid), 32'(pend.valid));
                chk("key_release", 32'(key_release), 32'(pend.rel));
                chk("key_code", 32'(key_code), 32'(pend.code));
                chk("key_held", 32'(key_held), 32'(pend.held));
            end else if (key_valid !== 1'b0 || key_release !== 1'b0 ||
                         key_code !== pend.code || key_held !== pend.held) begin
                ok_steady = 1'b0;
            end
        end
        chk("col_scan", 32'(ok_col), 32'd1);
        chk("steady_between_sweeps", 32'(ok_steady), 32'd1);
        pend = v;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        e;
        logic [15:0] m;
        int          n, s;

        pressed = K_NONE;
        rst_n   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_col_o", 32'(col_o), 32'h8);
        chk("rst_key_code", 32'(key_code), 32'h0);
        chk("rst_key_valid", 32'(key_valid), 32'h0);
        chk("rst_key_held", 32'(key_held), 32'h0);
        chk("rst_key_release", 32'(key_release), 32'h0);
        rst_n = 1'b1;
        pend  = mk(K_NONE, 1'b0, 1'b0, 4'd0, 1'b0);

        // Directed table: keys held during a sweep and the outputs expected after it ends.
        for (int i = 0; i < 10; i++) tbl.push_back(mk((i % 2 == 0) ? K6 : K_NONE, 0, 0, 4'd0, 0));
        for (int i = 0; i < 3; i++)  tbl.push_back(mk(K_NONE, 0, 0, 4'd0, 0));
        tbl.push_back(mk(K6, 0, 0, 4'd0, 0));
        tbl.push_back(mk(K6, 0, 0, 4'd0, 0));
        tbl.push_back(mk(K6, 1, 0, 4'd6, 1));
        tbl.push_back(mk(K6, 0, 0, 4'd6, 1));
        tbl.push_back(mk(K6, 0, 0, 4'd6, 1));
        tbl.push_back(mk(K_NONE, 0, 0, 4'd6, 1));
        tbl.push_back(mk(K_NONE, 0, 0, 4'd6, 1));
        tbl.push_back(mk(K_NONE, 0, 1, 4'd6, 0));
        tbl.push_back(mk(K3 | K9, 0, 0, 4'd6, 0));
        tbl.push_back(mk(K3 | K9, 0, 0, 4'd6, 0));
        tbl.push_back(mk(K3 | K9, 1, 0, 4'd3, 1));
        tbl.push_back(mk(K9, 0, 0, 4'd3, 1));
        tbl.push_back(mk(K9, 0, 0, 4'd3, 1));
        tbl.push_back(mk(K9, 1, 0, 4'd9, 1));
        tbl.push_back(mk(K_NONE, 0, 0, 4'd9, 1));
        tbl.push_back(mk(K_NONE, 0, 0, 4'd9, 1));
        tbl.push_back(mk(K9, 0, 0, 4'd9, 1));
        tbl.push_back(mk(K_NONE, 0, 0, 4'd9, 1));
        tbl.push_back(mk(K_NONE, 0, 0, 4'd9, 1));
        tbl.push_back(mk(K6, 0, 0, 4'd9, 1));
        tbl.push_back(mk(K6, 0, 0, 4'd9, 1));
        tbl.push_back(mk(K_NONE, 0, 0, 4'd9, 1));
        tbl.push_back(mk(K_NONE, 0, 0, 4'd9, 1));
        tbl.push_back(mk(K_NONE, 0, 1, 4'd9, 0));
        tbl.push_back(mk(K3, 0, 0, 4'd9, 0));
        tbl.push_back(mk(K3, 0, 0, 4'd9, 0));
        tbl.push_back(mk(K_NONE, 0, 0, 4'd9, 0));

        foreach (tbl[i]) begin
            model_sweep(tbl[i].keys, e);
            do_sweep(tbl[i]);
        end

        // Randomized key patterns held for random runs of sweeps.
        s = 0;
        while (s < 64) begin
            case ($urandom_range(0, 3))
                0:       m = K_NONE;
                3:       m = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
                default: m = 16'(1) << $urandom_range(0, 15);
            endcase
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                model_sweep(m, e);
                do_sweep(e);
                s++;
            end
        end

        // Get key 6 held, then reset mid-dwell while it stays pressed.
        for (int j = 0; j < 3; j++) begin
            model_sweep(K6, e);
            do_sweep(e);
        end
        pressed = K6;
        @(negedge clk);
        chk("held_before_reset", 32'(key_held), 32'd1);
        chk("code_before_reset", 32'(key_code), 32'd6);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_col_o", 32'(col_o), 32'h8);
        chk("async_key_code", 32'(key_code), 32'h0);
        chk("async_key_held", 32'(key_held), 32'h0);
        chk("async_key_valid", 32'(key_valid), 32'h0);
        chk("async_key_release", 32'(key_release), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        pend = mk(K_NONE, 1'b0, 1'b0, 4'd0, 1'b0);
        do_sweep(mk(K6, 0, 0, 4'd0, 0));
        do_sweep(mk(K6, 0, 0, 4'd0, 0));
        do_sweep(mk(K6, 1, 0, 4'd6, 1));
        do_sweep(mk(K6, 0, 0, 4'd6, 1));
        do_sweep(mk(K_NONE, 0, 0, 4'd6, 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
